uart_tx_arbiter: RTL

Shares one UART transmit serializer among NUM_REQ requesters using round-robin arbitration.
- Latches the winner's frame and drives the serializer's data/start inputs.
- Sequences each frame through launch, busy-observed and busy-released phases.
- Returns a one-cycle grant pulse to the winning requester.
- Sits between client blocks (command, status, debug sources) and the single uart transmitter.

---
 rtl/uart_pkg.sv | 19 +
 rtl/rr_pick.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state type, default frame
// width and an index-width helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_t;

    localparam int DEFAULT_DATA_W = 9;

    // clog2 of n, never below 1 so a 2-entry (or degenerate) index still has a bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: picks the first set request bit at or above
// ptr, wrapping modulo N (N need not be a power of two).
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    function automatic int wrap(input int v);
        return (v >= N) ? v - N : v;
    endfunction

    // Scan from the farthest offset down so the nearest set bit overrides the rest.
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[wrap(int'(ptr) + k)]) begin
                onehot                       = '0;
                onehot[wrap(int'(ptr) + k)]  = 1'b1;
                idx                          = IDX_W'(wrap(int'(ptr) + k));
                valid                        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART serializer among NUM_REQ requesters.
// Define UART_ARB_TIMEOUT_EN to add the start-timeout watchdog and sticky err_timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int  NUM_REQ       = 4,
    parameter int  DATA_W        = DEFAULT_DATA_W,
    parameter int  START_TIMEOUT = 16,
    localparam int IDX_W         = idx_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_start,
    input  logic                      tx_busy,
    output logic [IDX_W-1:0]          owner,
    output logic                      active,
    output logic                      err_timeout
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || START_TIMEOUT < 1) begin : g_bad_params
        $error("uart_tx_arbiter: unsupported parameter values");
    end

    arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic                active_q, active_d;
    logic [NUM_REQ-1:0]  pick_onehot;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;
    logic [IDX_W-1:0]    ptr_after_owner;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = idx_width(START_TIMEOUT);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
`endif

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    assign ptr_after_owner = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = '0;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        owner_d    = owner_q;
        active_d   = active_q;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            // A still-draining serializer blocks arbitration entirely.
            IDLE: begin
                if (!tx_busy && pick_valid) begin
                    gnt_d     = pick_onehot;
                    tx_data_d = req_data[int'(pick_idx)*DATA_W +: DATA_W];
                    owner_d   = pick_idx;
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                tx_start_d = 1'b1;
                active_d   = 1'b1;
                state_d    = WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
                cnt_d      = '0;
`endif
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                // Serializer never acknowledged: drop the frame and move on.
                else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
                    err_d    = 1'b1;
                    active_d = 1'b0;
                    ptr_d    = ptr_after_owner;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    ptr_d    = ptr_after_owner;
                    active_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gnt_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            owner_q    <= '0;
            active_q   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            owner_q    <= owner_d;
            active_q   <= active_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign gnt      = gnt_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign owner    = owner_q;
    assign active   = active_q;
`ifdef UART_ARB_TIMEOUT_EN
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule
